adc_feature_sequencer: RTL and testbench
========================================

# adc_feature_sequencer

Front-end sequencer that sits directly upstream of the combinational printed-MLP classifier. On a start request it steps an analog mux through each sensor channel, waits a settle interval, and requests one conversion per channel from the ADC over a req/ack handshake. It reduces each raw sample to the classifier's feature width by rounding and saturating, then stores it in a shadow register. When every channel has been captured, it updates the packed feature vector that drives the classifier `inp` bus in a single step and pulses `vec_valid`.

## Interface
Parameters:
- `N_FEAT`, default 9: number of features/channels. Must be ≥ 2.
- `FEAT_W`, default 4: bits per feature delivered to the classifier.
- `ADC_W`, default 8: raw ADC sample width. Must be > `FEAT_W`.
- `SETTLE`, default 2: cycles spent in the settle state after each mux change. Must be ≥ 1.
- `TIMEOUT`, default 16: maximum number of cycles to wait for `adc_ack` in the request state.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: requests one full acquisition. Sampled only in IDLE.
- `mux_sel`, out, ceil(log2 `N_FEAT`): analog mux channel select.
- `adc_req`, out, 1: conversion request. Registered.
- `adc_ack`, in, 1: conversion done. `adc_data` is valid in the same cycle.
- `adc_data`, in, `ADC_W`: raw sample.
- `feat_vec`, out, `N_FEAT*FEAT_W`: packed features. Channel k occupies bits [k*FEAT_W+FEAT_W-1 : k*FEAT_W].
- `vec_valid`, out, 1: one-cycle pulse, asserted when `feat_vec` has just been updated.
- `busy`, out, 1: high in every state other than IDLE.
- `err`, out, 1: sticky timeout flag. Cleared by the next accepted `start`.

## Operation
- States:
  - IDLE: `busy`=0. `start`=1 takes it to SETTLE, with channel `ch`=0, settle counter = `SETTLE`-1, and `err` cleared.
  - SETTLE: the counter decrements every cycle. On the edge where the counter is 0, go to REQ and load the timeout counter with `TIMEOUT`-1.
  - REQ: `adc_req`=1.
    - An edge sampling `adc_ack`=1 stores q into shadow slot `ch`.
    - If `ch` < `N_FEAT`-1: increment `ch` and return to SETTLE with the counter reloaded.
    - If `ch` = `N_FEAT`-1: load `feat_vec` from the shadow register, with q placed in the last slot in the same edge. Set `vec_valid`=1 for one cycle and go to IDLE.
    - An edge sampling `adc_ack`=0 with the timeout counter at 0 sets `err`=1 and goes to IDLE. `feat_vec` is unchanged and `vec_valid` is not asserted.
- `mux_sel` = `ch` at all times. It changes only on the edge that enters SETTLE.
- `adc_ack` is ignored outside REQ, and `start` is ignored while `busy`=1.
- Quantization, with D = `ADC_W`-`FEAT_W`:
  - t = (`adc_data` + 2^(D-1)) >> D, computed at `ADC_W`+1 bits so there is no wrap.
  - q = min(t, 2^`FEAT_W`-1).
- The shadow register is never cleared between runs. Slots are overwritten in order.

## Timing
- Reset values: IDLE, `ch`=0, `mux_sel`=0, `adc_req`=0, `busy`=0, `vec_valid`=0, `err`=0, `feat_vec`=0, shadow=0.
- Reset mid-acquisition aborts the run. No `vec_valid` is produced, and `feat_vec` returns to 0.
- Per channel: `SETTLE` cycles of settling plus the ack wait. With `adc_ack` tied high the ack wait is 1 cycle.
- With `adc_ack` tied high, `vec_valid` is high in the cycle starting `N_FEAT`*(`SETTLE`+1) edges after the edge that sampled `start`. At defaults this is 27 cycles.
- `feat_vec` is stable from the `vec_valid` cycle until the next successful completion. The downstream classifier may sample it at any time.
- If `start` is held high, the next run is accepted on the edge immediately after `vec_valid`, since `vec_valid` is asserted while in IDLE. This gives 1 idle cycle between runs.
- A timeout fires on the `TIMEOUT`-th edge in REQ without an ack. `err` is set from the following cycle.

## Test plan
- Reset then idle: with `adc_ack` held high and `start` low for 50 cycles, all outputs hold their reset values, and `adc_req` is never asserted.
- Quantization corners (defaults):
  - Drive channel samples 0x00, 0x07, 0x08, 0x17, 0x18, 0x7F, 0xF7, 0xF8, 0xFF.
  - Required `feat_vec` nibbles, ch0..ch8: 0, 0, 1, 1, 2, 8, 15, 15, 15.
  - Packed result: `feat_vec` = 36'hFFF821100.
- Latency: with `adc_ack` tied high, pulse `start` for one cycle. `vec_valid` pulses for exactly one cycle, 27 cycles later. `mux_sel` steps 0..8, holding each value for 3 cycles.
- Slow ADC: ack channel 4 after 5 cycles in REQ. The total latency grows by exactly 4 cycles, and the data is correct.
- Timeout: never ack channel 3. `err`=1 after 16 REQ cycles, state returns to IDLE, and `feat_vec` keeps its previous value. A new `start` clears `err`, and the run then completes.
- Reset and restart: assert `rst` during channel 5. `feat_vec`=0 and `busy`=0 on the next cycle. Continuous `start` afterwards gives back-to-back `vec_valid` pulses spaced 28 cycles apart.

Source files
------------

// File: rtl/adc_feature_sequencer.sv
// Acquisition sequencer ahead of the printed-MLP classifier: scans the analog mux,
// handshakes one ADC conversion per channel and publishes a quantized feature vector atomically.
module adc_feature_sequencer #(
  parameter int N_FEAT  = 9,
  parameter int FEAT_W  = 4,
  parameter int ADC_W   = 8,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [$clog2(N_FEAT)-1:0]  mux_sel,
  output logic                       adc_req,
  input  logic                       adc_ack,
  input  logic [ADC_W-1:0]           adc_data,
  output logic [N_FEAT*FEAT_W-1:0]   feat_vec,
  output logic                       vec_valid,
  output logic                       busy,
  output logic                       err
);

  localparam int SEL_W   = $clog2(N_FEAT);
  localparam int D       = ADC_W - FEAT_W;
  localparam int CNT_MAX = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [SEL_W-1:0] LAST_CH   = SEL_W'(N_FEAT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] TMO_LD    = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_REQ
  } state_t;

  // Round half-up to FEAT_W bits; one extra bit keeps the rounding add from wrapping.
  function automatic logic [FEAT_W-1:0] quantize(input logic [ADC_W-1:0] x);
    logic [ADC_W:0] t;
    t = ({1'b0, x} + (ADC_W+1)'(2 ** (D - 1))) >> D;
    if (t > (ADC_W+1)'(2 ** FEAT_W - 1)) quantize = '1;
    else                                 quantize = t[FEAT_W-1:0];
  endfunction

  state_t                          state_q, state_d;
  logic [SEL_W-1:0]                ch;
  logic [CNT_W-1:0]                cnt;
  logic [N_FEAT-1:0][FEAT_W-1:0]   shadow;
  logic [FEAT_W-1:0]               q_p0;
  logic                            accept, take, finish, tmo, last_ch, cnt_zero;

  assign q_p0     = quantize(adc_data);
  assign last_ch  = (ch == LAST_CH);
  assign cnt_zero = (cnt == '0);
  assign mux_sel  = ch;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    take    = 1'b0;
    finish  = 1'b0;
    tmo     = 1'b0;
    busy    = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_zero) state_d = ST_REQ;
      end
      ST_REQ: begin
        // An ack on the last permitted edge still wins over the timeout.
        if (adc_ack) begin
          take = 1'b1;
          if (last_ch) begin
            finish  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SETTLE;
          end
        end else if (cnt_zero) begin
          tmo     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ch        <= '0;
      cnt       <= '0;
      adc_req   <= 1'b0;
      vec_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      adc_req   <= (state_d == ST_REQ);
      vec_valid <= finish;
      if (accept) begin
        ch  <= '0;
        err <= 1'b0;
      end else if (take && !last_ch) begin
        ch <= ch + SEL_W'(1);
      end
      if (tmo) err <= 1'b1;
      // One counter serves both the settle interval and the ack timeout.
      if (accept || (take && !last_ch))               cnt <= SETTLE_LD;
      else if (state_q == ST_SETTLE && cnt_zero)      cnt <= TMO_LD;
      else if (state_q != ST_IDLE && !cnt_zero)       cnt <= cnt - CNT_W'(1);
    end
  end

  // Capture stage: shadow slot write and atomic vector publish
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow   <= '0;
      feat_vec <= '0;
    end else begin
      if (take) shadow[ch] <= q_p0;
      if (finish) begin
        for (int k = 0; k < N_FEAT - 1; k++)
          feat_vec[k*FEAT_W +: FEAT_W] <= shadow[k];
        feat_vec[(N_FEAT-1)*FEAT_W +: FEAT_W] <= q_p0;
      end
    end
  end

endmodule

// File: tb/tb_adc_feature_sequencer.sv
// Self-checking bench for adc_feature_sequencer: randomized samples and ack delays
// compared cycle by cycle against a schedule-level reference model.
module tb_adc_feature_sequencer;

  localparam int N_FEAT  = 9;
  localparam int FEAT_W  = 4;
  localparam int ADC_W   = 8;
  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 16;
  localparam int VW      = N_FEAT * FEAT_W;

  logic                 clk = 1'b0;
  logic                 rst, start, adc_ack;
  logic [ADC_W-1:0]     adc_data;
  logic [3:0]           mux_sel;
  logic                 adc_req, vec_valid, busy, err;
  logic [VW-1:0]        feat_vec;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_vv_cyc = -1;
  int samp [N_FEAT];
  int dly  [N_FEAT];
  logic [VW-1:0] model_vec = '0;

  adc_feature_sequencer #(
    .N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .ADC_W(ADC_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mux_sel(mux_sel), .adc_req(adc_req),
    .adc_ack(adc_ack), .adc_data(adc_data), .feat_vec(feat_vec), .vec_valid(vec_valid),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference quantizer: round-half-up divide, then clamp to the feature range.
  function automatic int mq(input int x);
    int t;
    t = (x + 2 ** (ADC_W - FEAT_W - 1)) / (2 ** (ADC_W - FEAT_W));
    return (t > 2 ** FEAT_W - 1) ? 2 ** FEAT_W - 1 : t;
  endfunction

  // One acquisition. Called on a negedge; checks every cycle from the start edge
  // to end_c+post. dly[k] = REQ cycles before ack (negative = never).
  task automatic run_acq(input bit hold, input int post, input string tag);
    int s [N_FEAT+1];
    int tmo_ch, last, end_c, req_cnt;
    logic [VW-1:0] new_vec;
    tmo_ch = -1;
    s[0]   = 0;
    for (int k = 0; k < N_FEAT; k++) begin
      if (tmo_ch < 0) begin
        if (dly[k] < 0 || dly[k] >= TIMEOUT) begin
          tmo_ch = k;
          s[k+1] = s[k] + SETTLE + TIMEOUT;
        end else begin
          s[k+1] = s[k] + SETTLE + 1 + dly[k];
        end
      end
    end
    last  = (tmo_ch < 0) ? N_FEAT - 1 : tmo_ch;
    end_c = s[last+1];
    for (int k = 0; k < N_FEAT; k++)
      new_vec[k*FEAT_W +: FEAT_W] = FEAT_W'(mq(samp[k]));
    start   = 1'b1;
    req_cnt = 0;
    for (int n = 0; n <= end_c + post; n++) begin
      int  ech;
      bit  ereq, edone;
      @(negedge clk);
      if (n == 0 && !hold) start = 1'b0;
      ech = last;
      for (int k = 0; k <= last; k++)
        if (n >= s[k] && n < s[k+1]) ech = k;
      ereq  = (n < end_c) && (n >= s[ech] + SETTLE);
      edone = (n >= end_c) && (tmo_ch < 0);
      chk({tag, ".mux_sel"},   64'(mux_sel),   64'(ech));
      chk({tag, ".adc_req"},   64'(adc_req),   64'(ereq));
      chk({tag, ".busy"},      64'(busy),      64'(n < end_c));
      chk({tag, ".vec_valid"}, 64'(vec_valid), 64'((n == end_c) && (tmo_ch < 0)));
      chk({tag, ".err"},       64'(err),       64'((tmo_ch >= 0) && (n >= end_c)));
      chk({tag, ".feat_vec"},  64'(feat_vec),  64'(edone ? new_vec : model_vec));
      if (vec_valid) last_vv_cyc = cyc;
      if (ereq) begin
        adc_ack  = (req_cnt == dly[ech]);
        adc_data = adc_ack ? ADC_W'(samp[ech]) : ADC_W'($urandom);
        req_cnt++;
      end else begin
        req_cnt  = 0;
        adc_ack  = 1'($urandom);
        adc_data = ADC_W'($urandom);
      end
    end
    if (tmo_ch < 0) model_vec = new_vec;
  endtask

  task automatic rand_setup(input int max_dly);
    for (int k = 0; k < N_FEAT; k++) begin
      samp[k] = int'($urandom_range(0, 2 ** ADC_W - 1));
      dly[k]  = int'($urandom_range(0, max_dly));
    end
  endtask

  initial begin
    int corner [N_FEAT] = '{'h00, 'h07, 'h08, 'h17, 'h18, 'h7F, 'hF7, 'hF8, 'hFF};
    int vv_a, vv_b;
    bit reached;
    rst = 1'b1; start = 1'b0; adc_ack = 1'b0; adc_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    adc_ack = 1'b1;
    // Idle after reset: ack high, no start
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle.outputs", 64'({mux_sel, adc_req, busy, vec_valid, err, feat_vec}), 64'(0));
    end

    for (int k = 0; k < N_FEAT; k++) begin samp[k] = corner[k]; dly[k] = 0; end
    run_acq(1'b0, 2, "corner");
    chk("corner.packed", 64'(feat_vec), 64'(36'hFFF821100));

    rand_setup(0);
    run_acq(1'b0, 2, "latency");

    rand_setup(0);
    dly[4] = 4;
    run_acq(1'b0, 2, "slow_adc");

    rand_setup(1);
    dly[3] = -1;
    run_acq(1'b0, 3, "timeout");
    rand_setup(2);
    run_acq(1'b0, 2, "after_tmo");

    rand_setup(1);
    dly[N_FEAT-1] = TIMEOUT - 1;
    run_acq(1'b0, 2, "ack_last_edge");

    for (int r = 0; r < 4; r++) begin
      rand_setup(3);
      run_acq(1'b0, 1 + r, "random");
    end

    // Reset in the middle of channel 5
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    adc_ack = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      adc_data = ADC_W'($urandom);
      if (mux_sel == 4'd5) reached = 1'b1;
      else @(negedge clk);
    end
    chk("rst.reach_ch5", 64'(reached), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst.feat_vec", 64'(feat_vec), 64'(0));
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.vec_valid", 64'(vec_valid), 64'(0));
    chk("rst.mux_sel", 64'(mux_sel), 64'(0));
    model_vec = '0;

    rand_setup(0);
    run_acq(1'b1, 0, "b2b_1");
    vv_a = last_vv_cyc;
    rand_setup(0);
    run_acq(1'b1, 0, "b2b_2");
    vv_b = last_vv_cyc;
    chk("b2b.spacing", 64'(vv_b - vv_a), 64'(28));
    rand_setup(0);
    run_acq(1'b0, 2, "b2b_3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
